pipelined_prefix_adder: RTL and testbench

//  Parametrised two-stage pipelined add/subtract unit built on per-bit generate cells.

---
 rtl/pipelined_prefix_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// Two-stage add/subtract unit: per-bit g/p/h registered, Kogge-Stone carry tree, registered sum/flags.
// Latency: 2 cycles from accepted operands to out_valid; 1 result/cycle sustained.
// Backpressure: out_ready low holds the result; stage 1 buffers one more, then in_ready drops.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake for a, b, cin, sub
//   a, b [WIDTH]            operands; sub=1 computes a-b (cin ignored), sub=0 computes a+b+cin
//   out_valid/out_ready     result handshake for sum, cout, ovf
//   sum [WIDTH]             result modulo 2^WIDTH
//   cout, ovf               carry out of the top bit, signed overflow
module pipelined_prefix_adder #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic             c0_q, c0_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             s2_load;
    logic [WIDTH-1:0] b_eff;

    // Prefix tree working values
    logic [WIDTH-1:0] gk, pk, gn, pn;
    logic [WIDTH:0]   c;

    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign b_eff    = sub ? ~b : b;

    // Stage 1: per-bit cells. p uses OR, which is safe for carries because g
    // dominates wherever both bits are set; the sum uses h only.
    always_comb begin
        g_d        = g_q;
        p_d        = p_q;
        h_d        = h_q;
        c0_d       = c0_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            g_d        = a & b_eff;
            p_d        = a | b_eff;
            h_d        = a ^ b_eff;
            c0_d       = sub ? 1'b1 : cin;
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Kogge-Stone tree: level l combines each bit with the span 2^l below it.
    // After the last level, (gk[i], pk[i]) covers bits [i:0].
    always_comb begin
        gk = g_q;
        pk = p_q;
        gn = g_q;
        pn = p_q;
        for (int l = 0; l < LEVELS; l++) begin
            gn = gk;
            pn = pk;
            for (int i = (1 << l); i < WIDTH; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
                pn[i] = pk[i] & pk[i - (1 << l)];
            end
            gk = gn;
            pk = pn;
        end
        c[0] = c0_q;
        for (int i = 0; i < WIDTH; i++) begin
            c[i + 1] = gk[i] | (pk[i] & c0_q);
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (s2_load) begin
            sum_d       = h_q ^ c[WIDTH-1:0];
            cout_d      = c[WIDTH];
            ovf_d       = c[WIDTH] ^ c[WIDTH-1];
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            g_q         <= '0;
            p_q         <= '0;
            h_q         <= '0;
            c0_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            g_q         <= g_d;
            p_q         <= p_d;
            h_q         <= h_d;
            c0_q        <= c0_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
module tb_pipelined_prefix_adder;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results in acceptance order: {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    pipelined_prefix_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic with the textbook signed-overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mcin, input logic msub);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         v;
        bp   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
        v    = (ma[W-1] == bp[W-1]) && (full[W-1] != ma[W-1]);
        return {v, full[W], full[W-1:0]};
    endfunction

    // One clock: drive at negedge, sample handshakes 1ns later, score outputs.
    task automatic run_cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic icin, input logic isub, input logic ordy,
                             output logic acc, output logic ohs);
        logic [W+1:0] e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        ohs = out_valid && out_ready;
        if (ohs) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sum", 64'(sum), 64'(e[W-1:0]));
                check_eq("cout", 64'(cout), 64'(e[W]));
                check_eq("ovf", 64'(ovf), 64'(e[W+1]));
            end
        end
        if (acc) exp_q.push_back(model(ia, ib, icin, isub));
    endtask

    task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                            input logic dcin, input logic dsub,
                            input logic [W-1:0] esum, input logic ecout, input logic eovf);
        logic acc, ohs;
        run_cycle(1'b1, da, db, dcin, dsub, 1'b1, acc, ohs);
        check_eq({tag, "_accept"}, 64'(acc), 64'd1);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, ohs);
        check_eq({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_sum"}, 64'(sum), 64'(esum));
        check_eq({tag, "_cout"}, 64'(cout), 64'(ecout));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    endtask

    initial begin
        logic acc, ohs;
        int   n_acc, n_out, first_out, last_out, n_in_total, n_out_total;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        directed("add_wrap", 6'd63, 6'd1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        directed("sub_borrow", 6'd5, 6'd7, 1'b0, 1'b1, 6'd62, 1'b0, 1'b0);
        directed("sub_ovf", 6'd32, 6'd1, 1'b0, 1'b1, 6'd31, 1'b1, 1'b1);
        directed("add_ovf", 6'd31, 6'd1, 1'b0, 1'b0, 6'd32, 1'b0, 1'b1);
        directed("add_cin", 6'd10, 6'd20, 1'b1, 1'b0, 6'd31, 1'b0, 1'b0);
        directed("sub_cin_ignored", 6'd9, 6'd4, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0);

        // Streaming: 8 back-to-back ops, results must come out on 8 consecutive cycles.
        n_acc = 0; n_out = 0; first_out = -1; last_out = -1;
        for (int k = 0; k < 12; k++) begin
            run_cycle(k < 8, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc, ohs);
            if (acc) n_acc++;
            if (ohs) begin
                n_out++;
                if (first_out < 0) first_out = k;
                last_out = k;
            end
        end
        check_eq("stream_accepts", 64'(n_acc), 64'd8);
        check_eq("stream_results", 64'(n_out), 64'd8);
        check_eq("stream_first_cycle", 64'(first_out), 64'd2);
        check_eq("stream_span", 64'(last_out - first_out), 64'd7);

        // Stall: consumer blocked for 4 cycles; two ops buffered, then backpressure.
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, acc, ohs);
            if (acc) n_acc++;
            if (k >= 2) begin
                check_eq("stall_in_ready", 64'(in_ready), 64'd0);
                check_eq("stall_out_valid", 64'(out_valid), 64'd1);
                check_eq("stall_sum_held", 64'(sum), 64'(exp_q[0][W-1:0]));
            end
        end
        check_eq("stall_accepts", 64'(n_acc), 64'd2);
        for (int k = 0; k < 6; k++) run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs);
        check_eq("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two ops in flight: everything discarded.
        run_cycle(1'b1, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, acc, ohs);
        run_cycle(1'b1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, acc, ohs);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_sum", 64'(sum), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs);
            check_eq("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Random traffic with random backpressure.
        n_in_total = 0; n_out_total = 0;
        for (int k = 0; k < 4000; k++) begin
            run_cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 3) != 0, acc, ohs);
            if (acc) n_in_total++;
            if (ohs) n_out_total++;
        end
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ohs);
            if (ohs) n_out_total++;
        end
        check_eq("rand_drained", 64'(exp_q.size()), 64'd0);
        check_eq("rand_count", 64'(n_out_total), 64'(n_in_total));
        check_eq("rand_idle_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
